// File: rtl/ps2_kb_rx.sv
// PS/2 keyboard receiver: deserialises device frames, folds F0/E0 prefixes
// into one {break, scancode} event per keystroke and queues it in a FIFO.
// Ports: clk, rst (async, active-high), ps2_clk/ps2_data (raw async pins),
//   ps2kb_rd (bus read strobe, level), ps2kb_key {valid, break, code},
//   parity_err and overflow (sticky error flags).
module ps2_kb_rx #(
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       ps2kb_rd,
    output logic [9:0] ps2kb_key,
    output logic       parity_err,
    output logic       overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [AW:0]   FULL    = (AW+1)'(FIFO_DEPTH);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RECV = 1'b1;

    logic [1:0]    clk_s;
    logic [1:0]    dat_s;
    logic          clk_d;
    logic          fall;
    logic          bit_in;

    logic [0:0]    state;
    logic [3:0]    bitcnt;
    logic [8:0]    shreg;
    logic [TW-1:0] tocnt;
    logic          frm_vld;
    logic [7:0]    frm_code;

    logic          rd_prev;
    logic          brk_pend;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [8:0]    mem [FIFO_DEPTH];

    logic          push_req;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s <= 2'b11;
            dat_s <= 2'b11;
            clk_d <= 1'b1;
        end else begin
            clk_s <= {clk_s[0], ps2_clk};
            dat_s <= {dat_s[0], ps2_data};
            clk_d <= clk_s[1];
        end
    end

    assign fall   = clk_d & ~clk_s[1];
    assign bit_in = dat_s[1];

    // shreg collects data bits then parity, LSB first, entering at the top;
    // the stop bit is checked straight off the pin sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            bitcnt     <= 4'd0;
            shreg      <= 9'd0;
            tocnt      <= '0;
            frm_vld    <= 1'b0;
            frm_code   <= 8'd0;
            parity_err <= 1'b0;
        end else begin
            frm_vld <= 1'b0;
            if (fall)
                tocnt <= '0;
            else if (tocnt != TO_LAST)
                tocnt <= tocnt + 1'b1;
            unique case (state)
                S_IDLE: begin
                    if (fall && !bit_in) begin
                        state  <= S_RECV;
                        bitcnt <= 4'd1;
                    end
                end
                S_RECV: begin
                    if (fall) begin
                        if (bitcnt == 4'd10) begin
                            state  <= S_IDLE;
                            bitcnt <= 4'd0;
                            if ((^shreg) && bit_in) begin
                                frm_vld  <= 1'b1;
                                frm_code <= shreg[7:0];
                            end else begin
                                parity_err <= 1'b1;
                            end
                        end else begin
                            shreg  <= {bit_in, shreg[8:1]};
                            bitcnt <= bitcnt + 1'b1;
                        end
                    end else if (tocnt == TO_LAST) begin
                        state  <= S_IDLE;
                        bitcnt <= 4'd0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign full     = (count == FULL);
    assign empty    = (count == '0);
    assign push_req = frm_vld && (frm_code != 8'hF0) && (frm_code != 8'hE0);
    assign pop      = ps2kb_rd & ~rd_prev & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push     = push_req & (~full | pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_prev  <= 1'b0;
            brk_pend <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            rd_prev <= ps2kb_rd;
            if (frm_vld) begin
                if (frm_code == 8'hF0)
                    brk_pend <= 1'b1;
                else if (frm_code != 8'hE0)
                    brk_pend <= 1'b0;
            end
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push_req && !push)
                overflow <= 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {brk_pend, frm_code};
    end

    assign ps2kb_key = empty ? 10'h000 : {1'b1, mem[rd_ptr]};

endmodule

// File: tb/tb_ps2_kb_rx.sv
// Self-checking bench for ps2_kb_rx: directed vector table, hand-written
// corner sequences and random frames against a queue-based reference model.
module tb_ps2_kb_rx;

    localparam int DEPTH = 8;
    localparam int TO    = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       ps2kb_rd = 1'b0;
    logic [9:0] ps2kb_key;
    logic       parity_err;
    logic       overflow;

    int checks = 0;
    int failures = 0;

    ps2_kb_rx #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
        .clk(clk),
        .rst(rst),
        .ps2_clk(ps2_clk),
        .ps2_data(ps2_data),
        .ps2kb_rd(ps2kb_rd),
        .ps2kb_key(ps2kb_key),
        .parity_err(parity_err),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    // reference model: queue of {break, code} events plus sticky flags
    logic [8:0] mq[$];
    bit m_brk, m_perr, m_ovf;

    function automatic void m_reset();
        mq.delete();
        m_brk = 0; m_perr = 0; m_ovf = 0;
    endfunction

    function automatic void m_pop();
        if (mq.size() != 0) void'(mq.pop_front());
    endfunction

    function automatic void m_frame(input logic [7:0] c, input bit good);
        if (!good) m_perr = 1;
        else if (c == 8'hF0) m_brk = 1;
        else if (c == 8'hE0) ;
        else begin
            if (mq.size() < DEPTH) mq.push_back({m_brk, c});
            else m_ovf = 1;
            m_brk = 0;
        end
    endfunction

    function automatic logic [9:0] m_key();
        return (mq.size() != 0) ? {1'b1, mq[0]} : 10'h000;
    endfunction

    task automatic chk(input string nm, input logic [9:0] got,
                       input logic [9:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic chk_model(input string nm);
        chk({nm, "_key"}, ps2kb_key, m_key());
        chk({nm, "_perr"}, {9'd0, parity_err}, {9'd0, m_perr});
        chk({nm, "_ovf"}, {9'd0, overflow}, {9'd0, m_ovf});
    endtask

    // one PS/2 bit; entered and left at posedge+1; optional rd pulse timed
    // so that the pop edge lands on the push cycle of this (stop) bit
    task automatic ps2_bit(input logic b, input bit pop_here);
        ps2_data = b;
        repeat (4) @(posedge clk);
        #1 ps2_clk = 1'b0;
        if (pop_here) begin
            repeat (3) @(posedge clk);
            #1 ps2kb_rd = 1'b1;
            repeat (2) @(posedge clk);
            #1 ps2kb_rd = 1'b0;
            repeat (3) @(posedge clk);
        end else begin
            repeat (8) @(posedge clk);
        end
        #1 ps2_clk = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] c, input bit bad_par,
                              input bit bad_stop, input bit pop_stop);
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(c[i], 1'b0);
        ps2_bit((~^c) ^ bad_par, 1'b0);
        ps2_bit(~bad_stop, pop_stop);
        ps2_data = 1'b1;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic rd_pulse();
        ps2kb_rd = 1'b1;
        repeat (2) @(posedge clk);
        #1 ps2kb_rd = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        ps2kb_rd = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        m_reset();
    endtask

    // op: 0 good frame, 1 bad parity, 2 bad stop, 3 read pulse
    typedef struct {
        int         op;
        logic [7:0] code;
        logic [9:0] key;
        logic       perr;
    } vec_t;

    vec_t tbl[$];

    initial begin
        tbl.push_back('{0, 8'h1C, 10'h21C, 1'b0});
        tbl.push_back('{3, 8'h00, 10'h000, 1'b0});
        tbl.push_back('{0, 8'hF0, 10'h000, 1'b0});
        tbl.push_back('{0, 8'h1C, 10'h31C, 1'b0});
        tbl.push_back('{3, 8'h00, 10'h000, 1'b0});
        tbl.push_back('{0, 8'hE0, 10'h000, 1'b0});
        tbl.push_back('{0, 8'hF0, 10'h000, 1'b0});
        tbl.push_back('{0, 8'h75, 10'h375, 1'b0});
        tbl.push_back('{3, 8'h00, 10'h000, 1'b0});
        tbl.push_back('{0, 8'hE0, 10'h000, 1'b0});
        tbl.push_back('{0, 8'h6B, 10'h26B, 1'b0});
        tbl.push_back('{3, 8'h00, 10'h000, 1'b0});
        tbl.push_back('{1, 8'h1C, 10'h000, 1'b1});
        tbl.push_back('{0, 8'h1D, 10'h21D, 1'b1});
        tbl.push_back('{3, 8'h00, 10'h000, 1'b1});
        tbl.push_back('{2, 8'h22, 10'h000, 1'b1});

        #2;
        chk("rst_key", ps2kb_key, 10'h000);
        chk("rst_perr", {9'd0, parity_err}, 10'h000);
        chk("rst_ovf", {9'd0, overflow}, 10'h000);
        do_reset();

        foreach (tbl[i]) begin
            if (tbl[i].op == 3) rd_pulse();
            else send_frame(tbl[i].code, tbl[i].op == 1, tbl[i].op == 2, 1'b0);
            chk($sformatf("vec%0d_key", i), ps2kb_key, tbl[i].key);
            chk($sformatf("vec%0d_perr", i), {9'd0, parity_err},
                {9'd0, tbl[i].perr});
            chk($sformatf("vec%0d_ovf", i), {9'd0, overflow}, 10'h000);
        end

        // overflow and ordering
        do_reset();
        for (int i = 0; i < 9; i++) send_frame(8'h10 + 8'(i), 0, 0, 0);
        chk("ovf_flag", {9'd0, overflow}, 10'h001);
        chk("ovf_head", ps2kb_key, 10'h210);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("ovf_pop%0d", i), ps2kb_key, 10'h210 + 10'(i));
            rd_pulse();
        end
        chk("ovf_empty", ps2kb_key, 10'h000);

        // read held high: one pop only
        do_reset();
        for (int i = 0; i < 3; i++) send_frame(8'h30 + 8'(i), 0, 0, 0);
        ps2kb_rd = 1'b1;
        repeat (10) @(posedge clk);
        #1 ps2kb_rd = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("hold_key1", ps2kb_key, 10'h231);
        rd_pulse();
        chk("hold_key2", ps2kb_key, 10'h232);
        rd_pulse();
        chk("hold_empty", ps2kb_key, 10'h000);

        // push coinciding with pop while full
        do_reset();
        for (int i = 0; i < 8; i++) send_frame(8'h40 + 8'(i), 0, 0, 0);
        send_frame(8'h48, 0, 0, 1);
        chk("cc_ovf", {9'd0, overflow}, 10'h000);
        for (int i = 1; i < 9; i++) begin
            chk($sformatf("cc_pop%0d", i), ps2kb_key, 10'h240 + 10'(i));
            rd_pulse();
        end
        chk("cc_empty", ps2kb_key, 10'h000);

        // timeout drops a partial frame
        do_reset();
        ps2_bit(1'b0, 0);
        ps2_bit(1'b1, 0);
        ps2_bit(1'b0, 0);
        ps2_bit(1'b1, 0);
        ps2_bit(1'b1, 0);
        repeat (TO + 20) @(posedge clk);
        #1;
        send_frame(8'h1C, 0, 0, 0);
        chk("to_key", ps2kb_key, 10'h21C);
        chk("to_perr", {9'd0, parity_err}, 10'h000);

        // reset mid-frame
        send_frame(8'h1C, 1, 0, 0);
        ps2_bit(1'b0, 0);
        ps2_bit(1'b1, 0);
        ps2_bit(1'b1, 0);
        rst = 1'b1;
        #1;
        chk("mr_key", ps2kb_key, 10'h000);
        chk("mr_perr", {9'd0, parity_err}, 10'h000);
        chk("mr_ovf", {9'd0, overflow}, 10'h000);
        ps2_data = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        send_frame(8'h2A, 0, 0, 0);
        chk("mr_after", ps2kb_key, 10'h22A);

        // random frames against the model
        do_reset();
        for (int n = 0; n < 70; n++) begin
            int sel;
            logic [7:0] c;
            bit bad, pstop;
            sel = $urandom_range(0, 11);
            if (sel == 0) begin
                rd_pulse();
                m_pop();
            end else begin
                if (sel == 1) c = 8'hF0;
                else if (sel == 2) c = 8'hE0;
                else c = 8'($urandom_range(1, 8'hDF));
                bad = ($urandom_range(0, 9) == 0);
                pstop = ($urandom_range(0, 5) == 0);
                send_frame(c, bad, 1'b0, pstop);
                if (pstop) m_pop();
                m_frame(c, !bad);
            end
            chk_model($sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_kb_rx.md
Name: ps2_kb_rx

Overview:
- PS/2 keyboard receiver with a key FIFO. Sits directly upstream of the memory-mapped IO bus decoder and drives its `ps2kb_key[9:0]` input.
- Deserialises PS/2 device frames, strips make/break prefixes and queues one 9-bit key event per keystroke.
- Pops one event per CPU read of the keyboard region (address `0xD0000000`), signalled by the bus's `ps2kb_rd` strobe.

Parameters:
- `FIFO_DEPTH`, 8, number of queued key events; power of 2, minimum 2.
- `TIMEOUT_CYC`, 100000, clk cycles without a `ps2_clk` falling edge before a partial frame is discarded (2 ms at 50 MHz).

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `ps2_clk`  in  1  raw PS/2 clock pin, asynchronous.
- `ps2_data`  in  1  raw PS/2 data pin, asynchronous.
- `ps2kb_rd`  in  1  read strobe from the bus decoder; level, may be held for several cycles.
- `ps2kb_key`  out  10  {valid, break, scancode[7:0]}; all zero when the FIFO is empty.
- `parity_err`  out  1  sticky; a frame failed the parity or stop check.
- `overflow`  out  1  sticky; an event was dropped because the FIFO was full.

Behaviour:
- Reset (async, `rst`=1):
  - Synchronisers to 1, receiver to IDLE, bit counter, shift register, timeout counter, FIFO pointers/count and `brk_pend` to 0.
  - `ps2kb_key`=0, `parity_err`=0, `overflow`=0, `rd_prev`=0.
  - Reset mid-frame discards the partial frame.
- Input conditioning:
  - `ps2_clk` and `ps2_data` each pass through a 2-FF synchroniser.
  - `fall` = previous synced clk is 1 and current synced clk is 0; one-cycle pulse.
  - Data is sampled from the synced `ps2_data` in the same cycle as `fall`.
- Receiver FSM:
  - IDLE: on `fall` with data=0 (start bit) go to RECV, bitcnt=1. On `fall` with data=1, ignore and stay.
  - RECV: on each `fall` shift the bit in (LSB first) and increment bitcnt. Bits 1-8 are data, bit 9 is parity, bit 10 is stop.
  - On the `fall` that captures the stop bit (bitcnt 10), the frame completes and the FSM returns to IDLE.
  - Frame valid iff XOR(data[7:0], parity)=1 (odd parity) and stop=1. Otherwise set `parity_err` and discard the frame.
  - Timeout: counter clears on every `fall` and counts otherwise, saturating. In RECV, when it reaches `TIMEOUT_CYC`-1, return to IDLE and discard the frame. No error flag is set.
- Decode, in the cycle after a valid frame completes:
  - code=`0xF0`: set `brk_pend`, no push.
  - code=`0xE0`: ignored; no push, `brk_pend` unchanged.
  - Any other code: push {`brk_pend`, code} and clear `brk_pend`.
- FIFO:
  - Circular buffer; `rd_ptr`/`wr_ptr` are log2(`FIFO_DEPTH`) bits and wrap naturally. Count is 0..`FIFO_DEPTH`.
  - Pop = `ps2kb_rd` & ~`rd_prev` & (count≠0), i.e. one pop per rising edge of `ps2kb_rd`. `rd_prev` is registered `ps2kb_rd`.
  - Pop on an empty FIFO is ignored.
  - Push when full without a simultaneous pop: drop the new event and set `overflow`.
  - Push and pop in the same cycle: both happen and count is unchanged. This includes the full case (push accepted) and excludes the empty case (pop ignored, push accepted).
- Output:
  - `ps2kb_key` = (count≠0) ? {1'b1, mem[`rd_ptr`]} : 10'h000. Purely a function of registered state, with no combinational path from the pins.
  - Latency: event is visible on `ps2kb_key` 2 clk cycles after the `fall` carrying the stop bit (decode/push cycle, then FIFO write).
  - After a pop, the next entry (or 0) is visible the following cycle.
  - Bus contract: the decoder reads `ps2kb_key` while `ps2kb_rd` is high, so the popped value is the one presented before the pop edge.

Test Plan:
- Make key: frame `0x1C` (valid parity, stop=1).
  - Two cycles after the stop edge, `ps2kb_key`=`10'h21C`.
  - One `ps2kb_rd` pulse → `ps2kb_key`=`10'h000`.
- Break and extended:
  - Frames `F0`,`1C` → single entry `10'h31C`.
  - Frames `E0`,`F0`,`75` → single entry `10'h375`.
  - Count stays 1 after each sequence.
- Parity error: frame `0x1C` with parity bit inverted → `parity_err`=1, FIFO empty. Following good frame `0x1D` → `10'h21D`.
- Overflow and ordering:
  - 9 frames `0x10`..`0x18` with no read → `overflow`=1, count=8.
  - 8 separate rd pulses return `10'h210`..`10'h217` in order, then `10'h000`.
- Read hold and concurrency:
  - `ps2kb_rd` held high 10 cycles with 3 entries → exactly one pop.
  - Push coinciding with a pop while full → count stays 8, no overflow.
- Timeout and reset:
  - Start + 4 bits, then idle `TIMEOUT_CYC` cycles → discarded. Next frame `0x1C` → `10'h21C`.
  - `rst` asserted mid-frame → all outputs 0 immediately. Subsequent frame received correctly.
